draw_player_anim: RTL

DRAW_PLAYER_ANIM -- requirements
Module: draw_player_anim

---
 rtl/draw_player_anim_if.sv | 21 ++
 rtl/draw_player_anim.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_player_anim_if.sv
// Shared types for the player sprite: character state encoding and the VGA pixel bus.
package state_pkg;
  typedef enum logic [1:0] {
    IDLE1  = 2'd0,
    RIGHT1 = 2'd1,
    LEFT1  = 2'd2
  } State1;
endpackage

interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_player_anim.sv
// Animated player sprite overlaid on a VGA stream through a 2-clock pipeline.
// Define DRAW_PLAYER_JUMP_EN to build in the jump state machine.
module draw_player_anim #(
  parameter logic [11:0] PLAYER_COLOR = 12'hF0F,
  parameter logic [11:0] EYE_COLOR    = 12'h0FF,
  parameter int          BASE_Y       = 410,
  parameter int          JUMP_H       = 64,
  parameter int          JUMP_STEP    = 8,
  parameter int          ANIM_DIV     = 8
) (
  input  logic                clk,
  input  logic                rst,
  vga_if.in                   vga_in,
  vga_if.out                  vga_out,
  input  logic [11:0]         xpos_player,
  input  state_pkg::State1    state,
  input  logic                jump,
  output logic                airborne
);

  localparam int WALK_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(ANIM_DIV - 1);

  // Range test on a relative coordinate; a set sign bit never hits.
  function automatic logic in_rng(input logic [12:0] v, input logic [12:0] lo,
                                  input logic [12:0] hi);
    return !v[12] && (v >= lo) && (v <= hi);
  endfunction

  function automatic logic in_eye(input logic [12:0] dx, input logic [12:0] dy,
                                  input logic [12:0] cx);
    logic [12:0]        ex;
    logic [12:0]        ey;
    logic signed [25:0] sx;
    logic signed [25:0] sy;
    ex = dx - cx;
    ey = dy - 13'd30;
    sx = $signed({{13{ex[12]}}, ex});
    sy = $signed({{13{ey[12]}}, ey});
    return !dx[12] && !dy[12] && ((sx * sx + sy * sy) <= 26'sd30);
  endfunction

  function automatic logic walk_legs(input logic [12:0] dxl, input logic phase);
    logic hit;
    if (phase) begin
      hit = in_rng(dxl, 13'd4, 13'd12) || in_rng(dxl, 13'd13, 13'd21);
    end else begin
      hit = in_rng(dxl, 13'd1, 13'd9) || in_rng(dxl, 13'd16, 13'd24);
    end
    return hit;
  endfunction

  logic                vblnk_prev_r;
  logic                tick_s;
  logic [11:0]         xpos_r;
  state_pkg::State1    state_r;
  logic [6:0]          jump_y_s;
  logic                grounded_s;
  logic [WALK_W-1:0]   walk_cnt_r;
  logic                walk_phase_r;

  assign tick_s = vga_in.vblnk & ~vblnk_prev_r;

  // Frame-tick edge detect and per-frame capture of position and state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vblnk_prev_r <= 1'b0;
      xpos_r       <= 12'd0;
      state_r      <= state_pkg::IDLE1;
    end else begin
      vblnk_prev_r <= vga_in.vblnk;
      if (tick_s) begin
        xpos_r  <= xpos_player;
        state_r <= state;
      end
    end
  end

`ifdef DRAW_PLAYER_JUMP_EN
  localparam logic [1:0] GROUND = 2'd0;
  localparam logic [1:0] RISE   = 2'd1;
  localparam logic [1:0] FALL   = 2'd2;
  localparam logic [7:0] JUMP_H_8    = 8'(JUMP_H);
  localparam logic [7:0] JUMP_STEP_8 = 8'(JUMP_STEP);

  logic [1:0] jstate_r;
  logic [1:0] jstate_nxt;
  logic [6:0] jump_y_r;
  logic [6:0] jump_y_nxt;

  // Jump next-state; the launch tick leaves the offset at 0.
  always_comb begin
    jstate_nxt = jstate_r;
    jump_y_nxt = jump_y_r;
    if (tick_s) begin
      case (jstate_r)
        GROUND: begin
          jump_y_nxt = 7'd0;
          if (jump) begin
            jstate_nxt = RISE;
          end else begin
            jstate_nxt = GROUND;
          end
        end
        RISE: begin
          if (({1'b0, jump_y_r} + JUMP_STEP_8) >= JUMP_H_8) begin
            jump_y_nxt = JUMP_H_8[6:0];
            jstate_nxt = FALL;
          end else begin
            jump_y_nxt = jump_y_r + JUMP_STEP_8[6:0];
            jstate_nxt = RISE;
          end
        end
        FALL: begin
          if ({1'b0, jump_y_r} <= JUMP_STEP_8) begin
            jump_y_nxt = 7'd0;
            jstate_nxt = GROUND;
          end else begin
            jump_y_nxt = jump_y_r - JUMP_STEP_8[6:0];
            jstate_nxt = FALL;
          end
        end
        default: begin
          jump_y_nxt = 7'd0;
          jstate_nxt = GROUND;
        end
      endcase
    end else begin
      jstate_nxt = jstate_r;
      jump_y_nxt = jump_y_r;
    end
  end

  // Jump state, offset and the airborne flag move together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      jstate_r <= GROUND;
      jump_y_r <= 7'd0;
      airborne <= 1'b0;
    end else begin
      jstate_r <= jstate_nxt;
      jump_y_r <= jump_y_nxt;
      airborne <= (jstate_nxt != GROUND);
    end
  end

  assign jump_y_s   = jump_y_r;
  assign grounded_s = (jstate_r == GROUND);
`else
  logic jump_unused_s;

  assign jump_unused_s = jump;
  assign jump_y_s      = 7'd0;
  assign grounded_s    = 1'b1;
  assign airborne      = 1'b0;
`endif

  // Walk animation: advances only while walking on the ground.
  always_ff @(posedge clk) begin
    if (!rst) begin
      walk_cnt_r   <= '0;
      walk_phase_r <= 1'b0;
    end else if (tick_s) begin
      case (state)
        state_pkg::RIGHT1, state_pkg::LEFT1: begin
          if (grounded_s) begin
            if (walk_cnt_r == WALK_LAST) begin
              walk_cnt_r   <= '0;
              walk_phase_r <= ~walk_phase_r;
            end else begin
              walk_cnt_r <= walk_cnt_r + WALK_W'(1'b1);
            end
          end
        end
        default: begin
          walk_cnt_r   <= '0;
          walk_phase_r <= 1'b0;
        end
      endcase
    end
  end

  logic signed [12:0] top_s;
  logic signed [12:0] dx_s;
  logic signed [12:0] dy_s;
  logic               leg_row_s;
  logic               eye_hit_s;
  logic               body_hit_s;

  assign top_s     = 13'(BASE_Y) - {6'd0, jump_y_s};
  assign dx_s      = {2'b00, vga_in.hcount} - {1'b0, xpos_r};
  assign dy_s      = {2'b00, vga_in.vcount} - top_s;
  assign leg_row_s = in_rng(dy_s, 13'd71, 13'd89);

  // Shape decode per captured state; unknown states draw nothing.
  always_comb begin
    eye_hit_s  = 1'b0;
    body_hit_s = 1'b0;
    case (state_r)
      state_pkg::IDLE1: begin
        eye_hit_s  = in_eye(dx_s, dy_s, 13'd10) || in_eye(dx_s, dy_s, 13'd27);
        body_hit_s = (in_rng(dy_s, 13'd0, 13'd9) &&
                      (in_rng(dx_s, 13'd1, 13'd9) || in_rng(dx_s, 13'd31, 13'd39)))
                  || (in_rng(dy_s, 13'd5, 13'd9) &&
                      (in_rng(dx_s, 13'd1, 13'd14) || in_rng(dx_s, 13'd26, 13'd39)))
                  || (in_rng(dy_s, 13'd10, 13'd69) && in_rng(dx_s, 13'd1, 13'd39))
                  || (leg_row_s &&
                      (in_rng(dx_s, 13'd1, 13'd14) || in_rng(dx_s, 13'd26, 13'd39)));
      end
      state_pkg::RIGHT1: begin
        eye_hit_s  = in_rng(dy_s, 13'd21, 13'd39) && in_rng(dx_s, 13'd25, 13'd29);
        body_hit_s = (in_rng(dy_s, 13'd1, 13'd70) && in_rng(dx_s, 13'd1, 13'd24))
                  || (leg_row_s && walk_legs(dx_s, walk_phase_r));
      end
      state_pkg::LEFT1: begin
        eye_hit_s  = in_rng(dy_s, 13'd21, 13'd39) && in_rng(dx_s, 13'd0, 13'd4);
        body_hit_s = (in_rng(dy_s, 13'd1, 13'd70) && in_rng(dx_s, 13'd6, 13'd29))
                  || (leg_row_s && walk_legs(dx_s - 13'd5, walk_phase_r));
      end
      default: begin
        eye_hit_s  = 1'b0;
        body_hit_s = 1'b0;
      end
    endcase
  end

  logic        eye_hit_r;
  logic        body_hit_r;
  logic [10:0] hcount_r;
  logic [10:0] vcount_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        hblnk_r;
  logic        vblnk_r;
  logic [11:0] rgb_r;
  logic [11:0] rgb_s;

  // Stage 1: hit flags alongside the delayed timing and background colour.
  always_ff @(posedge clk) begin
    if (!rst) begin
      eye_hit_r  <= 1'b0;
      body_hit_r <= 1'b0;
      hcount_r   <= 11'd0;
      vcount_r   <= 11'd0;
      hsync_r    <= 1'b0;
      vsync_r    <= 1'b0;
      hblnk_r    <= 1'b0;
      vblnk_r    <= 1'b0;
      rgb_r      <= 12'd0;
    end else begin
      eye_hit_r  <= eye_hit_s;
      body_hit_r <= body_hit_s;
      hcount_r   <= vga_in.hcount;
      vcount_r   <= vga_in.vcount;
      hsync_r    <= vga_in.hsync;
      vsync_r    <= vga_in.vsync;
      hblnk_r    <= vga_in.hblnk;
      vblnk_r    <= vga_in.vblnk;
      rgb_r      <= vga_in.rgb;
    end
  end

  always_comb begin
    if (eye_hit_r) begin
      rgb_s = EYE_COLOR;
    end else if (body_hit_r) begin
      rgb_s = PLAYER_COLOR;
    end else begin
      rgb_s = rgb_r;
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= 12'd0;
    end else begin
      vga_out.hcount <= hcount_r;
      vga_out.vcount <= vcount_r;
      vga_out.hsync  <= hsync_r;
      vga_out.vsync  <= vsync_r;
      vga_out.hblnk  <= hblnk_r;
      vga_out.vblnk  <= vblnk_r;
      vga_out.rgb    <= rgb_s;
    end
  end

endmodule
